// File: rtl/fft_job_arbiter.sv
// Round-robin arbiter sharing one 4-point FFT engine between two sources.
// Latches samples, runs the start/done handshake, returns tagged results.
module fft_job_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned ERRW        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [63:0]     req0_samples,
  input  logic [63:0]     req1_samples,
  output logic [1:0]      grant,
  output logic            busy,
  output logic            eng_start,
  output logic [63:0]     eng_samples,
  input  logic [63:0]     eng_freqs,
  input  logic            eng_done,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic            rsp_err,
  output logic [63:0]     rsp_data,
  output logic [ERRW-1:0] err_count
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_e;

  localparam logic [7:0] TLAST = 8'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic             start_q, start_d;
  logic [63:0]      samp_q, samp_d;
  logic             valid_q, valid_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic [63:0]      data_q, data_d;
  logic [ERRW-1:0]  cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic [7:0]       timer_q, timer_d;
  logic             win;

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    grant_d = 2'b00;
    start_d = 1'b0;
    samp_d  = samp_q;
    valid_d = valid_q;
    id_d    = id_q;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    win     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          unique case (1'b1)
            (req == 2'b11): win = rr_q;
            default:        win = req[1];
          endcase
          samp_d  = win ? req1_samples : req0_samples;
          grant_d = win ? 2'b10 : 2'b01;
          start_d = 1'b1;
          id_d    = win;
          state_d = START;
        end
      end
      START: begin
        timer_d = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          data_d  = eng_freqs;
          err_d   = 1'b0;
          valid_d = 1'b1;
          state_d = RESP;
        end else if (timer_q == TLAST) begin
          data_d  = 64'd0;
          err_d   = 1'b1;
          valid_d = 1'b1;
          if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      RESP: begin
        if (valid_q && rsp_ready) begin
          valid_d = 1'b0;
          rr_d    = ~id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      start_q <= 1'b0;
      samp_q  <= 64'd0;
      valid_q <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 64'd0;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      start_q <= start_d;
      samp_q  <= samp_d;
      valid_q <= valid_d;
      id_q    <= id_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q != IDLE);
  assign eng_start   = start_q;
  assign eng_samples = samp_q;
  assign rsp_valid   = valid_q;
  assign rsp_id      = id_q;
  assign rsp_err     = err_q;
  assign rsp_data    = data_q;
  assign err_count   = cnt_q;

endmodule

// File: tb/tb_fft_job_arbiter.sv
// Scoreboard bench for fft_job_arbiter with a behavioural engine model.
// Driver predicts each response; monitor checks it on the handshake.
module tb_fft_job_arbiter;

  localparam int T     = 8;
  localparam int EW    = 8;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [63:0]   s0, s1;
  logic [1:0]    grant;
  logic          busy;
  logic          eng_start;
  logic [63:0]   eng_samples;
  logic [63:0]   eng_freqs;
  logic          eng_done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic          rsp_err;
  logic [63:0]   rsp_data;
  logic [EW-1:0] err_count;

  typedef struct {
    logic        id;
    logic        err;
    logic [63:0] data;
    logic [7:0]  ecnt;
    int          lat;
  } exp_t;

  typedef struct {
    int          k;
    logic [63:0] f;
  } eng_t;

  exp_t sb[$];
  eng_t eq[$];

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   stray_cnt = 0;
  int   ecount = 0;
  logic last_served = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fft_job_arbiter #(
    .TIMEOUT_CYC(T),
    .ERRW(EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req0_samples(s0),
    .req1_samples(s1),
    .grant(grant),
    .busy(busy),
    .eng_start(eng_start),
    .eng_samples(eng_samples),
    .eng_freqs(eng_freqs),
    .eng_done(eng_done),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_err(rsp_err),
    .rsp_data(rsp_data),
    .err_count(err_count)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no event, expected one", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Engine: done k+2 cycles after start cycle 1 (k >= T means never)
  initial begin
    int   seen;
    eng_t e;
    seen = 0;
    eng_done = 1'b0;
    eng_freqs = 64'd0;
    forever begin
      @(negedge clk);
      if (stray_cnt != seen) begin
        seen = stray_cnt;
        eng_done = 1'b1;
        eng_freqs = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        eng_done = 1'b0;
      end else if (eng_start && !rst) begin
        if (eq.size() == 0) begin
          fail("engine_job_queue");
        end else begin
          e = eq.pop_front();
          if (e.k < T) begin
            repeat (e.k + 1) @(negedge clk);
            eng_done = 1'b1;
            eng_freqs = e.f;
            @(negedge clk);
            eng_done = 1'b0;
            eng_freqs = ~e.f;
          end
        end
      end
    end
  end

  // Monitor: pulse shapes, latency, stability, scoreboard compare
  initial begin
    logic        pv, pr, pid, perr, pstart;
    logic [63:0] pdata;
    int          st_cyc;
    exp_t        x;
    pv = 0; pr = 0; pid = 0; perr = 0; pstart = 0;
    pdata = 0; st_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0;
        pr = 0;
        pstart = 0;
      end else begin
        if (eng_start || grant != 2'b00) begin
          check("start_with_grant", {eng_start, $onehot(grant)}, 2'b11);
          check("start_one_cycle", pstart, 1'b0);
          st_cyc = cyc;
        end
        if (rsp_valid && !pv) begin
          if (sb.size() == 0) fail("unexpected_rsp");
          else check("rsp_latency", 64'(cyc - st_cyc), 64'(sb[0].lat));
        end
        if (rsp_valid && pv && !pr)
          check("rsp_stable", {rsp_id, rsp_err, rsp_data},
                {pid, perr, pdata});
        if (rsp_valid && rsp_ready && sb.size() > 0) begin
          x = sb.pop_front();
          check("rsp_id", rsp_id, x.id);
          check("rsp_err", rsp_err, x.err);
          check("rsp_data", rsp_data, x.data);
          check("err_count", err_count, x.ecnt);
        end
        pv = rsp_valid;
        pr = rsp_ready;
        pid = rsp_id;
        perr = rsp_err;
        pdata = rsp_data;
        pstart = eng_start;
      end
    end
  end

  // Issue one job and predict its grant and response
  task automatic issue(input logic [1:0] r, input int k,
                       input logic [63:0] f, input bit keep,
                       input bit rnd, output int n);
    logic w;
    exp_t x;
    eng_t e;
    e.k = k;
    e.f = f;
    eq.push_back(e);
    req = r;
    n = 0;
    do begin
      step();
      n++;
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
    end while (grant == 2'b00 && n < 200);
    if (grant == 2'b00) begin
      fail("grant_wait");
      req = 2'b00;
      return;
    end
    w = (r == 2'b11) ? ~last_served : r[1];
    check("grant", grant, w ? 2'b10 : 2'b01);
    check("eng_samples", eng_samples, w ? s1 : s0);
    check("busy_at_grant", busy, 1'b1);
    last_served = w;
    x.id = w;
    x.err = (k >= T);
    if (x.err && ecount < 255) ecount++;
    x.data = x.err ? 64'd0 : f;
    x.ecnt = 8'(ecount);
    x.lat = 2 + ((k < T - 1) ? k : T - 1);
    sb.push_back(x);
    if (!keep) req = 2'b00;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (sb.size() != 0 && n < 300) begin
      step();
      n++;
    end
    if (sb.size() != 0) fail("drain_wait");
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_ctl"},
          {grant, busy, eng_start, rsp_valid, rsp_id, rsp_err}, 0);
    check({nm, "_eng_samples"}, eng_samples, 0);
    check({nm, "_rsp_data"}, rsp_data, 0);
    check({nm, "_err_count"}, err_count, 0);
  endtask

  initial begin
    int n;
    int k;
    rst = 1'b1;
    req = 2'b00;
    s0 = 64'd0;
    s1 = 64'd0;
    rsp_ready = 1'b1;
    repeat (2) step();
    check_reset("reset");
    rst = 1'b0;
    step();

    // Contention: both requesting, alternating service
    s0 = rnd64();
    s1 = rnd64();
    for (int i = 0; i < 4; i++)
      issue(2'b11, $urandom_range(0, 4), rnd64(), 1'b1, 1'b0, n);
    req = 2'b00;
    drain();
    check("idle_after_contention", busy, 1'b0);

    // Single job with the known engine result
    s0 = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    issue(2'b01, 2, {16'hFFFE, 16'hFFFE, 16'h0002, 16'h000A},
          1'b0, 1'b0, n);
    drain();
    check("single_idle", {busy, rsp_valid}, 2'b00);

    // Backpressure: response held, requester 1 waits
    rsp_ready = 1'b0;
    s0 = rnd64();
    s1 = rnd64();
    issue(2'b01, 1, rnd64(), 1'b0, 1'b0, n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    if (!rsp_valid) fail("bp_rsp_wait");
    req = 2'b10;
    repeat (10) begin
      step();
      check("bp_busy", busy, 1'b1);
      check("bp_no_grant", grant, 2'b00);
    end
    rsp_ready = 1'b1;
    issue(2'b10, 3, rnd64(), 1'b0, 1'b0, n);
    check("bp_grant_delay", 64'(n), 64'd2);
    drain();

    // Done in the final timer cycle beats the timeout
    issue(2'b01, T - 1, rnd64(), 1'b0, 1'b0, n);
    drain();

    // Timeout
    issue(2'b10, NEVER, rnd64(), 1'b0, 1'b0, n);
    drain();
    check("timeout_err_count", err_count, 1);

    // Reset during WAIT aborts the job silently
    issue(2'b01, NEVER, rnd64(), 1'b0, 1'b0, n);
    repeat (3) step();
    rst = 1'b1;
    step();
    check_reset("reset_mid_wait");
    rst = 1'b0;
    sb.delete();
    ecount = 0;
    last_served = 1'b1;
    stray_cnt++;
    repeat (6) begin
      step();
      check("post_reset_quiet", {rsp_valid, busy}, 2'b00);
    end

    // Randomized mix with random backpressure
    for (int i = 0; i < 40; i++) begin
      s0 = rnd64();
      s1 = rnd64();
      k = $urandom_range(0, T + 2);
      issue(2'($urandom_range(1, 3)), k, rnd64(), 1'b0, 1'b1, n);
    end
    drain();

    // Saturating error counter
    for (int i = 0; i < 300; i++)
      issue(2'($urandom_range(1, 2)), NEVER, rnd64(), 1'b0, 1'b0, n);
    drain();
    check("err_count_saturated", err_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_job_arbiter.md
Name: fft_job_arbiter

Overview:
Shares one fft_4point_16bit engine between two independent sample sources (e.g. the switch/memory loader and a host streaming port). Selects a requester round-robin, latches its four 16-bit samples, drives the engine start/done handshake, and returns the four result bins tagged with the requester id. A watchdog returns an error response if the engine never signals done.

Parameters:
TIMEOUT_CYC, 64, max cycles spent in WAIT before an error response; legal range 2..255
ERRW, 8, width of saturating error counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  2  per-requester job request; held high with samples stable until matching grant bit
req0_samples  in  64  requester 0 samples {s3,s2,s1,s0}, s0 in [15:0]
req1_samples  in  64  requester 1 samples, same packing
grant  out  2  one-hot, one-cycle pulse: job accepted, samples captured
busy  out  1  high in any state other than IDLE
eng_start  out  1  one-cycle start pulse to engine
eng_samples  out  64  registered samples to engine, same packing
eng_freqs  in  64  engine result bins {f3,f2,f1,f0}
eng_done  in  1  engine completion, sampled only in WAIT
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that owns the response
rsp_err  out  1  1 = timeout, data is zero
rsp_data  out  64  captured eng_freqs
err_count  out  ERRW  saturating count of timeouts

Behaviour:
- Clock clk; reset rst, synchronous, active-high. Reset values: state IDLE, grant 0, eng_start 0, eng_samples 0, rsp_valid 0, rsp_id 0, rsp_err 0, rsp_data 0, err_count 0, rr pointer 0 (requester 0 has priority), timer 0. Reset mid-job aborts immediately; no response is issued for the aborted job.
- All outputs are registered. busy is decoded from the state register.
- IDLE: if req is nonzero, pick a winner: a sole requester wins; if both request, the requester indicated by rr pointer wins. At the edge: winner samples go to eng_samples, grant gets onehot(winner), eng_start goes to 1, rsp_id gets the winner, and state goes to START. With no request, stay in IDLE.
- START (one cycle): grant and eng_start are high during this cycle only. Clear timer to 0, then go to WAIT.
- WAIT: each cycle, if eng_done is high, capture eng_freqs into rsp_data, set rsp_err to 0 and rsp_valid to 1, then go to RESP. Otherwise, if timer equals TIMEOUT_CYC-1, set rsp_data to 0, rsp_err to 1 and rsp_valid to 1, increment err_count with saturation at all-ones, then go to RESP. Otherwise increment the timer.
- eng_done and timer expiry in the same cycle: done wins and no error is raised.
- eng_done outside WAIT is ignored.
- RESP: hold rsp_valid, rsp_id, rsp_err and rsp_data stable while rsp_ready is low. On rsp_valid && rsp_ready: clear rsp_valid, set rr pointer to ~rsp_id (the other requester gets priority), then go to IDLE.
- Minimum job latency: req seen in IDLE at cycle 0 → grant/eng_start at cycle 1 → WAIT from cycle 2. If the engine completes with eng_done high at cycle 2+k, rsp_valid rises at cycle 3+k.
- No new job is accepted until the response is consumed. Back-to-back throughput is one job per (engine latency + 4) cycles with rsp_ready tied high.
- req deasserted after grant has no effect on the running job. req held after grant is treated as a new job once the FSM returns to IDLE.
- eng_samples holds its value after the job until the next grant.

Test Plan:
- Single job: req=01, req0_samples={16'h0004,16'h0003,16'h0002,16'h0001}, model engine done 3 cycles after start, returning {16'hFFFE,16'hFFFE,16'h0002,16'h000A}. Required: grant=01 for 1 cycle, eng_start for 1 cycle, then rsp_valid with rsp_id=0, rsp_err=0 and that rsp_data; busy low after the handshake.
- Contention: req=11 held continuously, rsp_ready=1. Required grant order 01,10,01,10 across four jobs; rsp_id alternates 0,1,0,1; samples on eng_samples match the granted requester.
- Timeout: TIMEOUT_CYC=8, eng_done never asserted. Required: rsp_valid with rsp_err=1, rsp_data=0, exactly 8 WAIT cycles after START; err_count goes 0→1. Repeat 300 times with ERRW=8: err_count saturates at 255.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. Required: rsp fields stable, no grant despite req=10, busy=1. Raise rsp_ready: handshake occurs, then the requester 1 grant comes one cycle later.
- Done/timeout collision: eng_done pulses in the cycle where timer=TIMEOUT_CYC-1. Required: rsp_err=0, data captured, err_count unchanged.
- Reset mid-WAIT: assert rst for 1 cycle during WAIT. Required: all outputs at reset values the next cycle, no rsp_valid, and a later eng_done pulse is ignored.
